// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART on rib slave 2: CTRL/STATUS/BAUD/DATA registers,
// single-byte TX and RX holding registers and a level RX interrupt.
module uart_slave #(
   parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434,
   parameter logic [15:0] MIN_BAUD_DIV     = 16'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   output logic [31:0] o_rd_data,
   input  logic        i_wr_en,
   input  logic [31:0] i_wr_data,
   output logic        o_uart_tx,
   input  logic        i_uart_rx,
   output logic        o_irq
);

   // state   | meaning
   // S_IDLE  | line idle, waiting for a DATA write (TX) or a falling edge (RX)
   // S_START | start bit: TX drives 0 for N cycles; RX waits N/2 then checks it
   // S_DATA  | 8 data bits, LSB first, one per N cycles
   // S_STOP  | stop bit: TX drives 1; RX samples it and delivers the byte
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t      r_tx_state, w_tx_next, r_rx_state, w_rx_next;
   logic        r_tx_en, r_rx_en, r_rx_ie;
   logic [15:0] r_baud;
   logic        r_rx_valid, r_rx_overrun, r_frame_err;
   logic [7:0]  r_rx_data;
   logic [15:0] r_tx_period, r_tx_cnt, r_rx_period, r_rx_cnt;
   logic [2:0]  r_tx_bit, r_rx_bit;
   logic [7:0]  r_tx_shift, r_rx_shift;
   logic        r_rx_s1, r_rx_s2, r_rx_prev;

   logic [15:0] w_period;
   logic        w_wr_ctrl, w_wr_status, w_wr_baud, w_wr_data;
   logic        w_tx_busy, w_tx_start, w_tx_tc, w_rx_tc, w_rx_fall, w_rx_deliver;
   logic        w_clr_valid, w_unused;

   assign w_period    = (r_baud < MIN_BAUD_DIV) ? MIN_BAUD_DIV : r_baud;
   assign w_wr_ctrl   = i_wr_en && (i_addr[3:2] == 2'd0);
   assign w_wr_status = i_wr_en && (i_addr[3:2] == 2'd1);
   assign w_wr_baud   = i_wr_en && (i_addr[3:2] == 2'd2);
   assign w_wr_data   = i_wr_en && (i_addr[3:2] == 2'd3);
   assign w_clr_valid = w_wr_status && i_wr_data[1];
   assign w_tx_busy   = (r_tx_state != S_IDLE);
   assign w_tx_start  = w_wr_data && r_tx_en && !w_tx_busy;
   assign w_tx_tc     = (r_tx_cnt == 16'd0);
   assign w_rx_tc     = (r_rx_cnt == 16'd0);
   assign w_rx_fall   = r_rx_prev && !r_rx_s2;
   assign w_rx_deliver = r_rx_en && (r_rx_state == S_STOP) && w_rx_tc;
   assign w_unused    = ^{i_addr[31:4], i_addr[1:0], i_wr_data[31:16]};
   assign o_irq       = r_rx_valid && r_rx_ie;

   always_comb begin
      o_rd_data = 32'd0;
      case (i_addr[3:2])
         2'd0: o_rd_data = {29'd0, r_rx_ie, r_rx_en, r_tx_en};
         2'd1: o_rd_data = {28'd0, r_frame_err, r_rx_overrun, r_rx_valid, w_tx_busy};
         2'd2: o_rd_data = {16'd0, r_baud};
         default: o_rd_data = {24'd0, r_rx_data};
      endcase
   end

   // Status flags: a new event on the same edge as its W1C clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_en      <= 1'b0;
         r_rx_en      <= 1'b0;
         r_rx_ie      <= 1'b0;
         r_baud       <= DEFAULT_BAUD_DIV;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_frame_err  <= 1'b0;
         r_rx_data    <= 8'd0;
      end else begin
         if (w_wr_ctrl) {r_rx_ie, r_rx_en, r_tx_en} <= i_wr_data[2:0];
         if (w_wr_baud) r_baud <= i_wr_data[15:0];
         if (w_rx_deliver) r_rx_valid <= 1'b1;
         else if (w_clr_valid) r_rx_valid <= 1'b0;
         if (w_rx_deliver && r_rx_valid && !w_clr_valid) r_rx_overrun <= 1'b1;
         else if (w_wr_status && i_wr_data[2]) r_rx_overrun <= 1'b0;
         if (w_rx_deliver && !r_rx_s2) r_frame_err <= 1'b1;
         else if (w_wr_status && i_wr_data[3]) r_frame_err <= 1'b0;
         if (w_rx_deliver && (!r_rx_valid || w_clr_valid)) r_rx_data <= r_rx_shift;
      end
   end

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         S_IDLE:  if (w_tx_start) w_tx_next = S_START;
         S_START: if (w_tx_tc) w_tx_next = S_DATA;
         S_DATA:  if (w_tx_tc && r_tx_bit == 3'd7) w_tx_next = S_STOP;
         default: if (w_tx_tc) w_tx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state  <= S_IDLE;
         r_tx_period <= 16'd0;
         r_tx_cnt    <= 16'd0;
         r_tx_bit    <= 3'd0;
         r_tx_shift  <= 8'd0;
      end else begin
         r_tx_state <= w_tx_next;
         if (w_tx_start) begin
            r_tx_period <= w_period;
            r_tx_cnt    <= w_period - 16'd1;
            r_tx_shift  <= i_wr_data[7:0];
            r_tx_bit    <= 3'd0;
         end else if (r_tx_state != S_IDLE) begin
            if (w_tx_tc) begin
               r_tx_cnt <= r_tx_period - 16'd1;
               if (r_tx_state == S_DATA) begin
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_bit   <= r_tx_bit + 3'd1;
               end
            end else begin
               r_tx_cnt <= r_tx_cnt - 16'd1;
            end
         end
      end
   end

   assign o_uart_tx = (r_tx_state == S_START) ? 1'b0 :
                      (r_tx_state == S_DATA)  ? r_tx_shift[0] : 1'b1;

   always_comb begin
      w_rx_next = r_rx_state;
      if (!r_rx_en) w_rx_next = S_IDLE;
      else begin
         case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_tc) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tc && r_rx_bit == 3'd7) w_rx_next = S_STOP;
            default: if (w_rx_tc) w_rx_next = S_IDLE;
         endcase
      end
   end

   // The start-bit wait is half a period so later samples land mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_rx_state  <= S_IDLE;
         r_rx_period <= 16'd0;
         r_rx_cnt    <= 16'd0;
         r_rx_bit    <= 3'd0;
         r_rx_shift  <= 8'd0;
      end else begin
         r_rx_s1    <= i_uart_rx;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= r_rx_s2;
         r_rx_state <= w_rx_next;
         if (!r_rx_en) begin
            r_rx_bit <= 3'd0;
         end else if (r_rx_state == S_IDLE) begin
            if (w_rx_fall) begin
               r_rx_period <= w_period;
               r_rx_cnt    <= (w_period >> 1) - 16'd1;
               r_rx_bit    <= 3'd0;
            end
         end else if (w_rx_tc) begin
            r_rx_cnt <= r_rx_period - 16'd1;
            if (r_rx_state == S_DATA) begin
               r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
               r_rx_bit   <= r_rx_bit + 3'd1;
            end
         end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_slave.sv
// Bench for uart_slave: register vector table, cycle-exact TX line checks and
// an RX scoreboard of expected {rx_data, STATUS} per received frame.
module tb_uart_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr, i_wr_data, o_rd_data;
   logic        i_wr_en, o_uart_tx, i_uart_rx, o_irq;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        exp_irq;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [3:0] status;
   } rx_exp_t;

   vec_t    vecs[17];
   rx_exp_t sb[$];

   always #5 clk = ~clk;

   uart_slave dut (
      .clk       (clk),
      .rst       (rst),
      .i_addr    (i_addr),
      .o_rd_data (o_rd_data),
      .i_wr_en   (i_wr_en),
      .i_wr_data (i_wr_data),
      .o_uart_tx (o_uart_tx),
      .i_uart_rx (i_uart_rx),
      .o_irq     (o_irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      i_addr = a; i_wr_data = d; i_wr_en = 1'b1;
      @(posedge clk);
      #1 i_wr_en = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
      i_addr = a;
      #1 d = o_rd_data;
   endtask

   // Caller must be sitting on a negedge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int n);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         i_uart_rx = f[i];
         repeat (n) @(negedge clk);
      end
      i_uart_rx = 1'b1;
   endtask

   task automatic rx_check(input string name);
      rx_exp_t     e;
      logic [31:0] d;
      repeat (4) @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         read_reg(32'hC, d);
         chk({name, "_data"}, d, {24'd0, e.data});
         read_reg(32'h4, d);
         chk({name, "_status"}, d, {28'd0, e.status});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [9:0]  frm;

      vecs[0]  = '{"rst_ctrl",    1'b0, 32'h0,  32'h0,         32'h0,   1'b0};
      vecs[1]  = '{"rst_status",  1'b0, 32'h4,  32'h0,         32'h0,   1'b0};
      vecs[2]  = '{"rst_baud",    1'b0, 32'h8,  32'h0,         32'h1B2, 1'b0};
      vecs[3]  = '{"rst_data",    1'b0, 32'hC,  32'h0,         32'h0,   1'b0};
      vecs[4]  = '{"w_ctrl_hi",   1'b1, 32'h0,  32'hFFFF_FFF8, 32'h0,   1'b0};
      vecs[5]  = '{"ctrl_hi",     1'b0, 32'h0,  32'h0,         32'h0,   1'b0};
      vecs[6]  = '{"w_ctrl",      1'b1, 32'h0,  32'h6,         32'h0,   1'b0};
      vecs[7]  = '{"ctrl_rw",     1'b0, 32'h0,  32'h0,         32'h6,   1'b0};
      vecs[8]  = '{"w_baud",      1'b1, 32'h8,  32'hDEAD_0010, 32'h0,   1'b0};
      vecs[9]  = '{"baud_rw",     1'b0, 32'h8,  32'h0,         32'h10,  1'b0};
      vecs[10] = '{"baud_alias",  1'b0, 32'h18, 32'h0,         32'h10,  1'b0};
      vecs[11] = '{"w_status",    1'b1, 32'h4,  32'hF,         32'h0,   1'b0};
      vecs[12] = '{"status_noop", 1'b0, 32'h4,  32'h0,         32'h0,   1'b0};
      vecs[13] = '{"w_ctrl0",     1'b1, 32'h0,  32'h0,         32'h0,   1'b0};
      vecs[14] = '{"ctrl_clear",  1'b0, 32'h0,  32'h0,         32'h0,   1'b0};
      vecs[15] = '{"w_baud0",     1'b1, 32'h8,  32'h0,         32'h0,   1'b0};
      vecs[16] = '{"baud_zero",   1'b0, 32'h8,  32'h0,         32'h0,   1'b0};

      rst = 1'b1; i_addr = 32'h0; i_wr_data = 32'h0; i_wr_en = 1'b0; i_uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_tx", o_uart_tx, 1'b1);

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
         else begin
            read_reg(vecs[i].addr, d);
            chk(vecs[i].name, d, vecs[i].exp);
            chk({vecs[i].name, "_irq"}, o_irq, vecs[i].exp_irq);
         end
      end

      // TX disabled: DATA write ignored
      bus_write(32'hC, 32'h55);
      chk("tx_dis_line", o_uart_tx, 1'b1);
      read_reg(32'h4, d);
      chk("tx_dis_busy", d[0], 1'b0);

      // TX 0xA5 at 8 cycles/bit, cycle-exact line, ignored write at cycle 40
      bus_write(32'h8, 32'd8);
      bus_write(32'h0, 32'h1);
      frm = {1'b1, 8'hA5, 1'b0};
      bus_write(32'hC, 32'hA5);
      for (int c = 0; c < 80; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (c == 41) i_wr_en = 1'b0;
         chk($sformatf("tx_bit_c%0d", c), o_uart_tx, frm[c / 8]);
         if (c == 0 || c == 79) begin
            read_reg(32'h4, d);
            chk($sformatf("tx_busy_c%0d", c), d[0], 1'b1);
         end
         if (c == 40) begin
            i_addr = 32'hC; i_wr_data = 32'h3C; i_wr_en = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      read_reg(32'h4, d);
      chk("tx_busy_end", d[0], 1'b0);
      chk("tx_idle_line", o_uart_tx, 1'b1);
      i_addr = 32'hC; i_wr_data = 32'h0F; i_wr_en = 1'b1;
      @(posedge clk);
      #1 i_wr_en = 1'b0;
      chk("tx_b2b_line", o_uart_tx, 1'b0);
      read_reg(32'h4, d);
      chk("tx_b2b_busy", d[0], 1'b1);
      repeat (90) @(posedge clk);

      // RX basic with interrupt
      bus_write(32'h0, 32'h7);
      @(negedge clk);
      sb.push_back('{8'h3C, 4'h2});
      send_frame(8'h3C, 1'b1, 8);
      rx_check("rx_basic");
      chk("rx_irq_set", o_irq, 1'b1);
      bus_write(32'h4, 32'h2);
      read_reg(32'h4, d);
      chk("rx_w1c", d, 32'h0);
      chk("rx_irq_clr", o_irq, 1'b0);

      // Overrun: second byte dropped
      @(negedge clk);
      send_frame(8'h11, 1'b1, 8);
      send_frame(8'h22, 1'b1, 8);
      sb.push_back('{8'h11, 4'h6});
      rx_check("rx_overrun");
      bus_write(32'h4, 32'h6);

      // Glitch: 2-cycle low pulse
      @(negedge clk);
      i_uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      i_uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      sb.push_back('{8'h11, 4'h0});
      rx_check("rx_glitch");

      // Framing error: byte still delivered
      @(negedge clk);
      sb.push_back('{8'h55, 4'hA});
      send_frame(8'h55, 1'b0, 8);
      rx_check("rx_frame_err");
      bus_write(32'h4, 32'hA);

      // BAUD below the clamp: 4 cycles/bit
      bus_write(32'h8, 32'd1);
      @(negedge clk);
      sb.push_back('{8'h96, 4'h2});
      send_frame(8'h96, 1'b1, 4);
      rx_check("rx_baud_min");
      chk("rx_irq_min", o_irq, 1'b1);

      // Reset mid-TX frame
      bus_write(32'h8, 32'd8);
      bus_write(32'hC, 32'h00);
      repeat (20) @(negedge clk);
      chk("pre_rst_line", o_uart_tx, 1'b0);
      #2 rst = 1'b1;
      #1 chk("rst_async_tx", o_uart_tx, 1'b1);
      chk("rst_async_irq", o_irq, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      read_reg(32'h0, d); chk("rst2_ctrl", d, 32'h0);
      read_reg(32'h4, d); chk("rst2_status", d, 32'h0);
      read_reg(32'h8, d); chk("rst2_baud", d, 32'h1B2);
      read_reg(32'hC, d); chk("rst2_data", d, 32'h0);
      repeat (5) @(posedge clk);
      #1 chk("rst2_tx", o_uart_tx, 1'b1);

      // W1C of rx_valid on the delivery edge (stop sample at posedge 79)
      bus_write(32'h8, 32'd8);
      bus_write(32'h0, 32'h7);
      @(negedge clk);
      sb.push_back('{8'h11, 4'h2});
      send_frame(8'h11, 1'b1, 8);
      rx_check("rx_pre_w1c");
      @(negedge clk);
      fork
         send_frame(8'h5A, 1'b1, 8);
         begin
            repeat (77) @(negedge clk);
            bus_write(32'h4, 32'h2);
         end
      join
      sb.push_back('{8'h5A, 4'h2});
      rx_check("rx_w1c_same");
      bus_write(32'h4, 32'h2);

      // rx_en cleared mid-frame: nothing delivered
      @(negedge clk);
      fork
         send_frame(8'h77, 1'b1, 8);
         begin
            repeat (39) @(negedge clk);
            bus_write(32'h0, 32'h4);
         end
      join
      bus_write(32'h0, 32'h7);
      repeat (20) @(negedge clk);
      sb.push_back('{8'h5A, 4'h0});
      rx_check("rx_en_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
